// File: rtl/array_select_skid.sv
// array_select_skid
//   Registered lane-select stage: accepts WIDTH-bit words on a valid/ready
//   handshake, applies the static bit permutation O[k] = I[SEL[k]] on push,
//   and holds up to two permuted words in a skid buffer so that I_ready is
//   always a flop output and the downstream chain sees no combinational ready
//   path. Also keeps a wrap-around count of accepted words for debug.
//
// Optional feature: define ARRAY_SELECT_PARITY_EN to add O_par, the even
//   parity (^) of the head entry, computed at push time and stored per entry.
//
// Ports
//   CLK      in   1      clock, rising edge
//   RESET    in   1      synchronous reset, active high
//   I_data   in   WIDTH  upstream word
//   I_valid  in   1      upstream word valid
//   I_ready  out  1      stage can accept (registered)
//   O_data   out  WIDTH  permuted head-of-buffer word
//   O_valid  out  1      O_data valid
//   O_ready  in   1      downstream accepts O_data
//   O_occ    out  2      buffer occupancy 0..2
//   O_count  out  CNT_W  accepted words modulo 2^CNT_W
//   O_par    out  1      head parity (ARRAY_SELECT_PARITY_EN only)

module array_select_skid #(
  parameter int                     WIDTH = 4,
  parameter int                     IDX_W = 2,
  parameter logic [WIDTH*IDX_W-1:0] SEL   = 8'h90,
  parameter int                     CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] I_data,
  input  logic             I_valid,
  output logic             I_ready,
  output logic [WIDTH-1:0] O_data,
  output logic             O_valid,
  input  logic             O_ready,
  output logic [1:0]       O_occ,
  output logic [CNT_W-1:0] O_count
`ifdef ARRAY_SELECT_PARITY_EN
  ,
  output logic             O_par
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   perm;
  logic [WIDTH-1:0]   head_q, skid_q;
  logic               i_ready_q;
  logic [CNT_W-1:0]   count_q;
  logic               push, pop;
  logic               head_ld_in, head_ld_skid, skid_ld;

  // Static permutation: each output bit is a fixed wire from one input bit.
  // Out-of-range select fields tie the bit low.
  for (genvar k = 0; k < WIDTH; k++) begin : g_lane
    localparam logic [IDX_W-1:0] IDX = SEL[k*IDX_W +: IDX_W];
    if (int'(IDX) < WIDTH) begin : g_map
      assign perm[k] = I_data[IDX];
    end else begin : g_zero
      assign perm[k] = 1'b0;
    end
  end

  assign push = I_valid & i_ready_q;
  assign pop  = O_valid & O_ready;

  // Next-state and buffer load controls. In FULL, I_ready is already low, so
  // push cannot occur there.
  always_comb begin
    state_d      = state_q;
    head_ld_in   = 1'b0;
    head_ld_skid = 1'b0;
    skid_ld      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d    = ONE;
          head_ld_in = 1'b1;
        end
      end
      ONE: begin
        if (push && !pop) begin
          state_d = FULL;
          skid_ld = 1'b1;
        end else if (pop && !push) begin
          state_d = EMPTY;
        end else if (push && pop) begin
          head_ld_in = 1'b1;
        end
      end
      FULL: begin
        if (pop) begin
          state_d      = ONE;
          head_ld_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= EMPTY;
      i_ready_q <= 1'b0;
      head_q    <= '0;
      skid_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      // Ready is decided from the next occupancy so it never depends on
      // O_ready combinationally.
      i_ready_q <= (state_d != FULL);
      if (head_ld_in)        head_q <= perm;
      else if (head_ld_skid) head_q <= skid_q;
      if (skid_ld)           skid_q <= perm;
      if (push)              count_q <= count_q + CNT_W'(1);
    end
  end

`ifdef ARRAY_SELECT_PARITY_EN
  logic head_par_q, skid_par_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      head_par_q <= 1'b0;
      skid_par_q <= 1'b0;
    end else begin
      if (head_ld_in)        head_par_q <= ^perm;
      else if (head_ld_skid) head_par_q <= skid_par_q;
      if (skid_ld)           skid_par_q <= ^perm;
    end
  end

  assign O_par = head_par_q;
`endif

  assign I_ready = i_ready_q;
  assign O_data  = head_q;
  assign O_valid = (state_q != EMPTY);
  assign O_occ   = state_q;
  assign O_count = count_q;

endmodule

// File: tb/tb_array_select_skid.sv
// Bench for array_select_skid: directed scenarios plus randomized traffic.
// A queue-based reference model is advanced at each falling edge from the
// inputs that the next rising edge will sample; outputs are compared
// against it whenever they are observable.

module tb_array_select_skid;
  localparam int          WIDTH = 4;
  localparam int          IDX_W = 2;
  localparam logic [7:0]  SEL   = 8'h90;
  localparam int          CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] i_data;
  logic             i_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             o_ready;
  logic [1:0]       o_occ;
  logic [CNT_W-1:0] o_count;
`ifdef ARRAY_SELECT_PARITY_EN
  logic             o_par;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  array_select_skid #(
    .WIDTH(WIDTH), .IDX_W(IDX_W), .SEL(SEL), .CNT_W(CNT_W)
  ) dut (
    .CLK(clk), .RESET(rst),
    .I_data(i_data), .I_valid(i_valid), .I_ready(i_ready),
    .O_data(o_data), .O_valid(o_valid), .O_ready(o_ready),
    .O_occ(o_occ), .O_count(o_count)
`ifdef ARRAY_SELECT_PARITY_EN
    , .O_par(o_par)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference permutation: output bit k copies input bit SEL field k.
  function automatic logic [WIDTH-1:0] ref_perm(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    logic [7:0]       sel;
    int               idx;
    sel = SEL;
    r = '0;
    for (int k = 0; k < WIDTH; k++) begin
      idx = (sel >> (k * IDX_W)) % (1 << IDX_W);
      r[k] = (idx < WIDTH) ? d[idx] : 1'b0;
    end
    return r;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [WIDTH-1:0] mq[$];
  int               m_count = 0;
  bit               m_ready = 0;
  bit               m_zero  = 0;   // O_data must read 0 (post-reset, no push yet)
  bit               armed   = 0;

  always @(negedge clk) begin
    if (armed) begin
      chk("occ",     int'(o_occ),   mq.size());
      chk("o_valid", int'(o_valid), int'(mq.size() != 0));
      chk("i_ready", int'(i_ready), int'(m_ready));
      chk("count",   int'(o_count), m_count % (1 << CNT_W));
      if (mq.size() != 0) begin
        chk("o_data", int'(o_data), int'(mq[0]));
`ifdef ARRAY_SELECT_PARITY_EN
        chk("o_par", int'(o_par), int'(^mq[0]));
`endif
      end else if (m_zero) begin
        chk("o_data_rst", int'(o_data), 0);
`ifdef ARRAY_SELECT_PARITY_EN
        chk("o_par_rst", int'(o_par), 0);
`endif
      end
    end
    // advance the model with what the coming edge will sample
    if (rst) begin
      mq.delete();
      m_count = 0;
      m_ready = 0;
      m_zero  = 1;
      armed   = 1;
    end else if (armed) begin
      bit do_push, do_pop;
      do_push = i_valid && m_ready;
      do_pop  = o_ready && (mq.size() != 0);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(ref_perm(i_data));
        m_count++;
        m_zero = 0;
      end
      m_ready = (mq.size() < 2);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; i_valid = 0; o_ready = 0;
    step(); step();
    rst = 0;
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; i_valid = 0; i_data = '0; o_ready = 0;
    step(); step();
    chk("rst_i_ready", int'(i_ready), 0);
    chk("rst_o_valid", int'(o_valid), 0);
    chk("rst_o_data",  int'(o_data),  0);
    rst = 0;
    step();
    chk("i_ready_after_rst", int'(i_ready), 1);

    // single push with downstream ready
    i_data = 4'b0101; i_valid = 1; o_ready = 1;
    step();
    i_valid = 0;
    chk("first_data",  int'(o_data),  4'b1011);
    chk("first_count", int'(o_count), 1);
    chk("first_occ",   int'(o_occ),   1);
    step();

    // fill with downstream stalled; third word must be ignored
    o_ready = 0;
    i_data = 4'h3; i_valid = 1; step();
    i_data = 4'hC; step();
    chk("full_occ",   int'(o_occ),   2);
    chk("full_ready", int'(i_ready), 0);
    i_data = 4'hF; step();
    i_valid = 0;
    chk("ignored_count", int'(o_count), 3);
    chk("ignored_occ",   int'(o_occ),   2);

    // drain in order
    o_ready = 1;
    chk("drain0", int'(o_data), 4'h7);
    step();
    chk("drain1", int'(o_data), 4'h8);
    step();
    chk("drained_occ",   int'(o_occ),   0);
    chk("drained_valid", int'(o_valid), 0);

    // simultaneous push and pop at occ=1
    o_ready = 0;
    i_data = 4'h5; i_valid = 1; step();
    i_data = 4'h2; o_ready = 1; step();
    i_valid = 0;
    chk("pp_occ",  int'(o_occ),  1);
    chk("pp_data", int'(o_data), 4'h4);
    step();
    o_ready = 0;

`ifdef ARRAY_SELECT_PARITY_EN
    o_ready = 1;
    i_data = 4'b0001; i_valid = 1; step();
    chk("par0_data", int'(o_data), 4'b0011);
    chk("par0",      int'(o_par),  0);
    i_data = 4'b0100; step();
    i_valid = 0;
    chk("par1_data", int'(o_data), 4'b1000);
    chk("par1",      int'(o_par),  1);
    step();
    o_ready = 0;
`endif

    // counter wrap: 256 pushes after reset
    do_reset();
    o_ready = 1; i_valid = 1;
    for (int n = 0; n < 256; n++) begin
      i_data = 4'($urandom);
      step();
    end
    i_valid = 0;
    chk("wrap_count", int'(o_count), 0);
    step();

    // reset while full
    o_ready = 0; i_valid = 1;
    i_data = 4'h9; step();
    i_data = 4'h6; step();
    i_valid = 0;
    chk("pre_rst_occ", int'(o_occ), 2);
    rst = 1; step();
    chk("mid_rst_valid", int'(o_valid), 0);
    chk("mid_rst_occ",   int'(o_occ),   0);
    chk("mid_rst_ready", int'(i_ready), 0);
    rst = 0; step();
    chk("mid_rst_ready_after", int'(i_ready), 1);

    // randomized traffic with occasional reset
    for (int n = 0; n < 3000; n++) begin
      i_valid = 1'($urandom_range(0, 2) != 0);
      i_data  = 4'($urandom);
      o_ready = 1'($urandom_range(0, 2) != 0);
      rst     = 1'($urandom_range(0, 199) == 0);
      step();
    end
    rst = 0; i_valid = 0; o_ready = 1;
    step(); step(); step();
    chk("final_occ", int'(o_occ), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
